// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the mm:ss.cc stopwatch.
// Optional lap hold is enabled by defining STOPWATCH_LAP_EN.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  localparam bcd_t DIGIT_MAX_UNITS = 4'd9;
  localparam bcd_t DIGIT_MAX_TENS  = 4'd5;

  typedef struct packed {
    bcd_t m_hi;
    bcd_t m_lo;
    bcd_t s_hi;
    bcd_t s_lo;
    bcd_t cs_hi;
    bcd_t cs_lo;
  } sw_time_t;

  // start_stop walks IDLE->RUN->PAUSE->RUN->...
  function automatic sw_state_t ss_next(
    input sw_state_t s
  );
    unique case (s)
      IDLE:    ss_next = RUN;
      RUN:     ss_next = PAUSE;
      PAUSE:   ss_next = RUN;
      default: ss_next = IDLE;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit with modulus MAX+1 and ripple carry out.
// Values above MAX (never expected) wrap to 0 on the next inc.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = DIGIT_MAX_UNITS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output bcd_t q,
  output logic carry
);

  bcd_t val;
  logic at_max;

  assign at_max = (val >= MAX);
  assign carry  = inc & at_max;
  assign q      = val;

  // Count on inc, wrap at MAX, clear wins over inc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val <= '0;
    end else if (clr) begin
      val <= '0;
    end else if (inc) begin
      val <= at_max ? bcd_t'(0) : val + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// mm:ss.cc stopwatch with 1/100 s prescaler and BCD digit chain.
// Define STOPWATCH_LAP_EN to enable the lap (display hold) feature.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int CLK_PER_TICK = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_stop,
  input  logic clear,
  input  logic lap,
  output bcd_t cs_lo,
  output bcd_t cs_hi,
  output bcd_t s_lo,
  output bcd_t s_hi,
  output bcd_t m_lo,
  output bcd_t m_hi,
  output logic running,
  output logic overflow,
  output logic lap_active
);

  localparam int PW = $clog2(CLK_PER_TICK);
  localparam logic [PW-1:0] PRESC_LAST =
    PW'(CLK_PER_TICK - 1);

  sw_state_t      state;
  sw_state_t      state_d;
  logic [PW-1:0]  presc;
  logic           tick;
  logic           wrap;
  sw_time_t       live;
  sw_time_t       display;

  logic c_cs_lo;
  logic c_cs_hi;
  logic c_s_lo;
  logic c_s_hi;
  logic c_m_lo;

  // Next state: clear dominates, otherwise start_stop toggles.
  always_comb begin
    state_d = state;
    if (clear) begin
      state_d = IDLE;
    end else if (start_stop) begin
      state_d = ss_next(state);
    end
  end

  // State and registered running flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_d;
      running <= (state_d == RUN);
    end
  end

  assign tick = (state == RUN) && (presc == PRESC_LAST);

  // Prescaler advances only in RUN and holds in PAUSE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (clear) begin
      presc <= '0;
    end else if (state == RUN) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  bcd_digit #(.MAX(DIGIT_MAX_UNITS)) u_cs_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (tick),
    .q     (live.cs_lo),
    .carry (c_cs_lo)
  );

  bcd_digit #(.MAX(DIGIT_MAX_UNITS)) u_cs_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (c_cs_lo),
    .q     (live.cs_hi),
    .carry (c_cs_hi)
  );

  bcd_digit #(.MAX(DIGIT_MAX_UNITS)) u_s_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (c_cs_hi),
    .q     (live.s_lo),
    .carry (c_s_lo)
  );

  bcd_digit #(.MAX(DIGIT_MAX_TENS)) u_s_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (c_s_lo),
    .q     (live.s_hi),
    .carry (c_s_hi)
  );

  bcd_digit #(.MAX(DIGIT_MAX_UNITS)) u_m_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (c_s_hi),
    .q     (live.m_lo),
    .carry (c_m_lo)
  );

  bcd_digit #(.MAX(DIGIT_MAX_TENS)) u_m_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (c_m_lo),
    .q     (live.m_hi),
    .carry (wrap)
  );

  // Overflow is sticky until clear or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (wrap) begin
      overflow <= 1'b1;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic     lap_q;
  sw_time_t snap;
  logic     lap_toggle;
  logic     lap_release;

  assign lap_toggle  = lap && !clear && (state == RUN);
  assign lap_release = lap && !clear && (state == PAUSE)
                       && lap_q;

  // Lap hold: snapshot the shown time when the hold starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_q <= 1'b0;
      snap  <= '0;
    end else if (clear) begin
      lap_q <= 1'b0;
    end else if (lap_toggle) begin
      lap_q <= ~lap_q;
      if (!lap_q) begin
        snap <= live;
      end
    end else if (lap_release) begin
      lap_q <= 1'b0;
    end
  end

  assign lap_active = lap_q;
  assign display    = lap_q ? snap : live;
`else
  logic unused_lap;

  assign unused_lap = lap;
  assign lap_active = 1'b0;
  assign display    = live;
`endif

  assign cs_lo = display.cs_lo;
  assign cs_hi = display.cs_hi;
  assign s_lo  = display.s_lo;
  assign s_hi  = display.s_hi;
  assign m_lo  = display.m_lo;
  assign m_hi  = display.m_hi;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: centisecond-count model plus
// directed literal checks and randomized pulses.
module tb_stopwatch_counter;

  localparam int CPT  = 2;
  localparam int WRAP = 360000;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic [3:0] cs_lo, cs_hi, s_lo, s_hi, m_lo, m_hi;
  logic       running, overflow, lap_active;

  int n_chk = 0;
  int n_err = 0;

  // model: total centiseconds, run state 0=idle 1=run 2=pause
  int m_state = 0;
  int m_presc = 0;
  int m_cnt   = 0;
  bit m_ovf   = 0;
  bit m_lap   = 0;
  int m_snap  = 0;
  bit pl_go   = 0;
  int pl_val  = 0;

  stopwatch_counter #(.CLK_PER_TICK(CPT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .cs_lo      (cs_lo),
    .cs_hi      (cs_hi),
    .s_lo       (s_lo),
    .s_hi       (s_hi),
    .m_lo       (m_lo),
    .m_hi       (m_hi),
    .running    (running),
    .overflow   (overflow),
    .lap_active (lap_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0;
      m_presc <= 0;
      m_cnt   <= 0;
      m_ovf   <= 0;
      m_lap   <= 0;
      m_snap  <= 0;
    end else if (clear) begin
      m_state <= 0;
      m_presc <= 0;
      m_cnt   <= 0;
      m_ovf   <= 0;
      m_lap   <= 0;
    end else begin
      if (m_state == 1)
        m_presc <= (m_presc == CPT - 1) ? 0 : m_presc + 1;
      if (pl_go)
        m_cnt <= pl_val;
      else if (m_state == 1 && m_presc == CPT - 1) begin
        m_cnt <= (m_cnt + 1) % WRAP;
        if (m_cnt == WRAP - 1) m_ovf <= 1;
      end
      if (start_stop)
        m_state <= (m_state == 1) ? 2 : 1;
      if (LAP_EN && lap) begin
        if (m_state == 1) begin
          m_lap <= !m_lap;
          if (!m_lap) m_snap <= m_cnt;
        end else if (m_state == 2) begin
          m_lap <= 0;
        end
      end
    end
  end

  function automatic logic [23:0] to_bcd(input int d);
    int mn, sc, cc;
    mn = d / 6000;
    sc = (d / 100) % 60;
    cc = d % 100;
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10),
            4'(sc % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  function automatic logic [26:0] dut_vec();
    return {m_hi, m_lo, s_hi, s_lo, cs_hi, cs_lo,
            running, overflow, lap_active};
  endfunction

  function automatic logic [26:0] model_vec();
    return {to_bcd(m_lap ? m_snap : m_cnt),
            m_state == 1, m_ovf, m_lap};
  endfunction

  task automatic compare();
    logic [26:0] a, e;
    a = dut_vec();
    e = model_vec();
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL cycle t=%0t dut=%h model=%h", $time, a, e);
    end
  endtask

  task automatic check_lit(input string name, input logic [23:0] d,
                           input bit run, input bit ovf,
                           input bit la);
    logic [26:0] e;
    e = {d, run, ovf, la};
    n_chk++;
    if (dut_vec() !== e) begin
      n_err++;
      $display("FAIL %s dut=%h want=%h", name, dut_vec(), e);
    end
    n_chk++;
    if (model_vec() !== e) begin
      n_err++;
      $display("FAIL %s_model model=%h want=%h", name, model_vec(), e);
    end
  endtask

  task automatic step(input logic ss, input logic cl, input logic lp);
    start_stop = ss;
    clear      = cl;
    lap        = lp;
    @(posedge clk);
    #1;
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
    compare();
  endtask

  task automatic wait_cnt(input int target, input int bound);
    int k = 0;
    while (m_cnt != target && k < bound) begin
      step(0, 0, 0);
      k++;
    end
    n_chk++;
    if (m_cnt != target) begin
      n_err++;
      $display("FAIL wait_cnt got=%0d want=%0d", m_cnt, target);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_lit("reset", 24'h000000, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0);

    step(1, 0, 0);
    repeat (20) step(0, 0, 0);
    check_lit("run20", 24'h000010, 1, 0, 0);

    wait_cnt(5999, 30000);
    check_lit("pre_min", 24'h005999, 1, 0, 0);
    wait_cnt(6000, 4);
    check_lit("minute", 24'h010000, 1, 0, 0);

    step(0, 1, 0);
    check_lit("clear", 24'h000000, 0, 0, 0);
    step(1, 0, 0);
    wait_cnt(5, 20);
    step(1, 0, 0);
    repeat (100) step(0, 0, 0);
    check_lit("pause", 24'h000005, 0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    check_lit("resume", 24'h000006, 1, 0, 0);

    step(1, 1, 0);
    check_lit("clr_ss", 24'h000000, 0, 0, 0);

    step(1, 0, 0);
    wait_cnt(3, 20);
    step(0, 0, 1);
    wait_cnt(13, 40);
    check_lit("lap_hold", LAP_EN ? 24'h000003 : 24'h000013,
              1, 0, LAP_EN);
    step(0, 0, 1);
    check_lit("lap_rel", 24'h000013, 1, 0, 0);

    step(0, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    force dut.u_m_hi.val  = 4'd5;
    force dut.u_m_lo.val  = 4'd9;
    force dut.u_s_hi.val  = 4'd5;
    force dut.u_s_lo.val  = 4'd9;
    force dut.u_cs_hi.val = 4'd9;
    force dut.u_cs_lo.val = 4'd9;
    #1;
    release dut.u_m_hi.val;
    release dut.u_m_lo.val;
    release dut.u_s_hi.val;
    release dut.u_s_lo.val;
    release dut.u_cs_hi.val;
    release dut.u_cs_lo.val;
    pl_val = WRAP - 1;
    pl_go  = 1'b1;
    step(0, 0, 0);
    pl_go  = 1'b0;
    check_lit("preload", 24'h595999, 0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    check_lit("wrap", 24'h000000, 1, 1, 0);
    repeat (10) step(0, 0, 0);
    check_lit("sticky", 24'h000005, 1, 1, 0);
    step(0, 1, 0);
    check_lit("wrap_clr", 24'h000000, 0, 0, 0);

    step(1, 0, 0);
    repeat (7) step(0, 0, 0);
    rst_n = 1'b0;
    #1;
    check_lit("async_rst", 24'h000000, 0, 0, 0);
    step(1, 0, 1);
    step(0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0);

    repeat (20000)
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 999) < 2,
           $urandom_range(0, 99) < 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
